// File: rtl/sid_loop_pkg.sv
// Shared types and helpers for the DAC->plant->ADC loop emulator.
package sid_loop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [31:0] CERO_MAGNITUD = '0;

    // Callers sign-extend the sample to 32 bits and truncate the result back.
    function automatic logic signed [31:0] asr_shift(input logic signed [31:0] i_val,
                                                     input logic [31:0]        i_sh);
        return i_val >>> i_sh;
    endfunction

endpackage

// File: rtl/loop_ring_ram.sv
// Sample ring buffer: one synchronous write port, two combinational read taps.
module loop_ring_ram #(
    parameter int DATA_W     = 14,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0]     o_rd_data_a,
    output logic [DATA_W-1:0]     o_rd_data_b
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_a = r_mem[i_rd_addr_a];
    assign o_rd_data_b = r_mem[i_rd_addr_b];

endmodule

// File: rtl/dac_adc_loop_emulator.sv
// On-chip DAC->ADC loop: two delayed, arithmetically attenuated copies of the DAC stream.
module dac_adc_loop_emulator
    import sid_loop_pkg::*;
#(
    parameter int MAGNITUD_WIDTH = 14,
    parameter int ADDR_WIDTH     = 6,
    parameter int SHIFT_WIDTH    = 2
) (
    input  logic                      clk125,
    input  logic                      areset_n,
    input  logic                      enable,
    input  logic                      cfg_load,
    input  logic [ADDR_WIDTH-1:0]     cfg_delay_a,
    input  logic [ADDR_WIDTH-1:0]     cfg_delay_b,
    input  logic [SHIFT_WIDTH-1:0]    cfg_shift_a,
    input  logic [SHIFT_WIDTH-1:0]    cfg_shift_b,
    input  logic [MAGNITUD_WIDTH-1:0] dac_in,
    input  logic                      dac_valid,
    output logic [MAGNITUD_WIDTH-1:0] adc_a,
    output logic [MAGNITUD_WIDTH-1:0] adc_b,
    output logic                      adc_valid,
    output logic                      busy
);

    localparam logic [ADDR_WIDTH-1:0]     FILL_MAX = '1;
    localparam logic [MAGNITUD_WIDTH-1:0] ZERO_S   = MAGNITUD_WIDTH'(CERO_MAGNITUD);

    state_t                    r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_wr_ptr, r_fill_cnt;
    logic [ADDR_WIDTH-1:0]     r_dly_a, r_dly_b, w_dly_max;
    logic [SHIFT_WIDTH-1:0]    r_sh_a, r_sh_b;
    logic [MAGNITUD_WIDTH-1:0] r_adc_a, r_adc_b;
    logic                      r_adc_valid;
    logic                      w_active, w_wr_en;
    logic [ADDR_WIDTH-1:0]     w_rd_addr_a, w_rd_addr_b;
    logic [MAGNITUD_WIDTH-1:0] w_ram_a, w_ram_b;
    logic signed [MAGNITUD_WIDTH-1:0] w_tap_a, w_tap_b, w_att_a, w_att_b;

    assign w_active    = (r_state != IDLE);
    assign w_wr_en     = w_active & dac_valid & ~cfg_load;
    assign w_dly_max   = (r_dly_a > r_dly_b) ? r_dly_a : r_dly_b;
    assign w_rd_addr_a = r_wr_ptr - r_dly_a;
    assign w_rd_addr_b = r_wr_ptr - r_dly_b;

    loop_ring_ram #(
        .DATA_W     (MAGNITUD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk       (clk125),
        .i_wr_en     (w_wr_en),
        .i_wr_addr   (r_wr_ptr),
        .i_wr_data   (dac_in),
        .i_rd_addr_a (w_rd_addr_a),
        .i_rd_addr_b (w_rd_addr_b),
        .o_rd_data_a (w_ram_a),
        .o_rd_data_b (w_ram_b)
    );

    // Zero delay bypasses the RAM; fill_cnt gating hides slots not yet written since the flush.
    always_comb begin
        w_tap_a = (r_dly_a == '0) ? signed'(dac_in) : signed'(w_ram_a);
        w_tap_b = (r_dly_b == '0) ? signed'(dac_in) : signed'(w_ram_b);
        w_att_a = signed'(ZERO_S);
        w_att_b = signed'(ZERO_S);
        if (r_fill_cnt >= r_dly_a) begin
            w_att_a = MAGNITUD_WIDTH'(asr_shift(32'(w_tap_a), 32'(r_sh_a)));
        end
        if (r_fill_cnt >= r_dly_b) begin
            w_att_b = MAGNITUD_WIDTH'(asr_shift(32'(w_tap_b), 32'(r_sh_b)));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (cfg_load) begin
            w_state_nxt = enable ? FILL : IDLE;
        end else if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = FILL;
                FILL:    if (r_fill_cnt >= w_dly_max) w_state_nxt = RUN;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk125) begin
        if (!areset_n) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_dly_a     <= '0;
            r_dly_b     <= '0;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_adc_a     <= ZERO_S;
            r_adc_b     <= ZERO_S;
            r_adc_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_adc_valid <= w_wr_en;
            if (cfg_load) begin
                r_dly_a    <= cfg_delay_a;
                r_dly_b    <= cfg_delay_b;
                r_sh_a     <= cfg_shift_a;
                r_sh_b     <= cfg_shift_b;
                r_fill_cnt <= '0;
                r_adc_a    <= ZERO_S;
                r_adc_b    <= ZERO_S;
            end else if (!w_active) begin
                r_wr_ptr   <= '0;
                r_fill_cnt <= '0;
                r_adc_a    <= ZERO_S;
                r_adc_b    <= ZERO_S;
            end else if (dac_valid) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                if (r_fill_cnt != FILL_MAX) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                r_adc_a    <= w_att_a;
                r_adc_b    <= w_att_b;
            end
        end
    end

    assign adc_a     = r_adc_a;
    assign adc_b     = r_adc_b;
    assign adc_valid = r_adc_valid;
    assign busy      = (r_state == FILL);

endmodule

// File: tb/tb_dac_adc_loop_emulator.sv
// Directed bench for dac_adc_loop_emulator with hand-derived expected values.
module tb_dac_adc_loop_emulator;

    logic        clk125 = 1'b0;
    logic        areset_n;
    logic        enable;
    logic        cfg_load;
    logic [5:0]  cfg_delay_a, cfg_delay_b;
    logic [1:0]  cfg_shift_a, cfg_shift_b;
    logic [13:0] dac_in;
    logic        dac_valid;
    logic [13:0] adc_a, adc_b;
    logic        adc_valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    dac_adc_loop_emulator dut (
        .clk125      (clk125),
        .areset_n    (areset_n),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .cfg_delay_a (cfg_delay_a),
        .cfg_delay_b (cfg_delay_b),
        .cfg_shift_a (cfg_shift_a),
        .cfg_shift_b (cfg_shift_b),
        .dac_in      (dac_in),
        .dac_valid   (dac_valid),
        .adc_a       (adc_a),
        .adc_b       (adc_b),
        .adc_valid   (adc_valid),
        .busy        (busy)
    );

    always #4 clk125 = ~clk125;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk125);
        #1;
    endtask

    function automatic int sa();
        return int'($signed(adc_a));
    endfunction

    function automatic int sb();
        return int'($signed(adc_b));
    endfunction

    task automatic load_cfg(input int da, input int db, input int sha, input int shb);
        cfg_load    = 1'b1;
        cfg_delay_a = 6'(da);
        cfg_delay_b = 6'(db);
        cfg_shift_a = 2'(sha);
        cfg_shift_b = 2'(shb);
        tick();
        cfg_load  = 1'b0;
        dac_valid = 1'b0;
    endtask

    task automatic feed(input int v);
        dac_in    = 14'(v);
        dac_valid = 1'b1;
        tick();
        dac_valid = 1'b0;
    endtask

    initial begin
        int exp_a, exp_b;
        int hold_a, hold_b;
        areset_n = 1'b0; enable = 1'b0; cfg_load = 1'b0;
        cfg_delay_a = '0; cfg_delay_b = '0; cfg_shift_a = '0; cfg_shift_b = '0;
        dac_in = '0; dac_valid = 1'b0;

        // Reset state
        tick(); tick();
        check_eq("rst_adc_a", sa(), 0);
        check_eq("rst_adc_b", sb(), 0);
        check_eq("rst_valid", int'(adc_valid), 0);
        check_eq("rst_busy", int'(busy), 0);

        // Ramp, delays 20/30, shifts 0/2
        areset_n = 1'b1;
        enable   = 1'b1;
        load_cfg(20, 30, 0, 2);
        check_eq("ramp_busy0", int'(busy), 1);
        check_eq("ramp_a0", sa(), 0);
        for (int n = 1; n <= 40; n++) begin
            feed(n);
            exp_a = (n > 20) ? n - 20 : 0;
            exp_b = (n > 30) ? (n - 30) >>> 2 : 0;
            check_eq($sformatf("ramp_a[%0d]", n), sa(), exp_a);
            check_eq($sformatf("ramp_b[%0d]", n), sb(), exp_b);
            check_eq($sformatf("ramp_vld[%0d]", n), int'(adc_valid), 1);
            if (n <= 29) check_eq($sformatf("ramp_busy[%0d]", n), int'(busy), 1);
            if (n >= 31) check_eq($sformatf("ramp_busy[%0d]", n), int'(busy), 0);
        end

        // Negative samples, pass-through with shift
        load_cfg(0, 0, 3, 0);
        check_eq("neg_flush_a", sa(), 0);
        feed(-8);
        check_eq("neg_a_m8", sa(), -1);
        check_eq("neg_b_m8", sb(), -8);
        feed(-9);
        check_eq("neg_a_m9", sa(), -2);
        check_eq("neg_b_m9", sb(), -9);
        feed(-8192);
        check_eq("neg_a_min", sa(), -1024);
        check_eq("neg_b_min", sb(), -8192);
        feed(13);
        check_eq("neg_a_p13", sa(), 1);

        // Maximum delay across pointer wraps
        load_cfg(63, 1, 0, 1);
        for (int n = 1; n <= 200; n++) begin
            feed(n);
            exp_a = (n > 63) ? n - 63 : 0;
            exp_b = (n > 1) ? (n - 1) >>> 1 : 0;
            check_eq($sformatf("wrap_a[%0d]", n), sa(), exp_a);
            check_eq($sformatf("wrap_b[%0d]", n), sb(), exp_b);
        end
        check_eq("wrap_busy", int'(busy), 0);

        // Gaps in dac_valid: delay counts samples
        load_cfg(5, 0, 0, 0);
        for (int n = 1; n <= 12; n++) begin
            feed(n);
            exp_a = (n > 5) ? n - 5 : 0;
            check_eq($sformatf("gap_a[%0d]", n), sa(), exp_a);
            check_eq($sformatf("gap_b[%0d]", n), sb(), n);
            check_eq($sformatf("gap_vld[%0d]", n), int'(adc_valid), 1);
            hold_a = sa();
            hold_b = sb();
            dac_in = 14'(999);
            for (int g = 0; g < 2; g++) begin
                tick();
                check_eq($sformatf("gap_idle_vld[%0d]", n), int'(adc_valid), 0);
                check_eq($sformatf("gap_hold_a[%0d]", n), sa(), hold_a);
                check_eq($sformatf("gap_hold_b[%0d]", n), sb(), hold_b);
            end
        end

        // cfg_load coincident with a valid sample while running
        check_eq("pre_load_busy", int'(busy), 0);
        dac_in    = 14'(500);
        dac_valid = 1'b1;
        load_cfg(3, 2, 0, 0);
        check_eq("load_a0", sa(), 0);
        check_eq("load_b0", sb(), 0);
        check_eq("load_vld", int'(adc_valid), 0);
        check_eq("load_busy", int'(busy), 1);
        for (int k = 1; k <= 8; k++) begin
            feed(100 + k);
            exp_a = (k > 3) ? 100 + k - 3 : 0;
            exp_b = (k > 2) ? 100 + k - 2 : 0;
            check_eq($sformatf("reload_a[%0d]", k), sa(), exp_a);
            check_eq($sformatf("reload_b[%0d]", k), sb(), exp_b);
            if (k <= 2) check_eq($sformatf("reload_busy[%0d]", k), int'(busy), 1);
            if (k >= 5) check_eq($sformatf("reload_busy[%0d]", k), int'(busy), 0);
        end

        // Reset pulse mid-run, then refill must not expose stale RAM
        areset_n  = 1'b0;
        dac_in    = 14'(55);
        dac_valid = 1'b1;
        tick();
        check_eq("mid_rst_a", sa(), 0);
        check_eq("mid_rst_b", sb(), 0);
        check_eq("mid_rst_vld", int'(adc_valid), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        areset_n = 1'b1;
        dac_in   = 14'(777);
        tick();
        dac_valid = 1'b0;
        check_eq("idle_ignore_vld", int'(adc_valid), 0);
        check_eq("idle_ignore_a", sa(), 0);
        check_eq("reenable_busy", int'(busy), 1);
        load_cfg(4, 10, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            feed(200 + k);
            exp_a = (k > 4) ? 200 + k - 4 : 0;
            exp_b = (k > 10) ? 200 + k - 10 : 0;
            check_eq($sformatf("post_rst_a[%0d]", k), sa(), exp_a);
            check_eq($sformatf("post_rst_b[%0d]", k), sb(), exp_b);
        end

        // Dropping enable returns to idle with cleared outputs
        enable = 1'b0;
        tick(); tick();
        check_eq("disable_a", sa(), 0);
        check_eq("disable_b", sb(), 0);
        check_eq("disable_busy", int'(busy), 0);
        check_eq("disable_vld", int'(adc_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
